// File: rtl/uart_echo_pkg.sv
// Shared types and character constants for the UART echo responder.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdPulse,
    StRdWait,
    StTxWait,
    StWrPulse
  } state_e;

  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] LOWER_A     = 8'h61;
  localparam logic [7:0] LOWER_Z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/uart_echo_responder_if.sv
// Host-port signals between the echo responder (master) and uart_protocol (slave).
interface uart_echo_responder_if #(
  parameter int unsigned DATA_SIZE = 8
) ();

  logic [7:0]           rx_status;
  logic [7:0]           tx_status;
  logic [DATA_SIZE-1:0] bus_rdata;
  logic                 read_data;
  logic                 write_data;
  logic [DATA_SIZE-1:0] bus_wdata;

  modport master (
    input  rx_status,
    input  tx_status,
    input  bus_rdata,
    output read_data,
    output write_data,
    output bus_wdata
  );

  modport slave (
    output rx_status,
    output tx_status,
    output bus_rdata,
    input  read_data,
    input  write_data,
    input  bus_wdata
  );

endinterface

// File: rtl/uart_echo_settle_cnt.sv
// Loadable down-counter that saturates at zero; gates trust in a status flag after a bus pulse.
module uart_echo_settle_cnt #(
  parameter int unsigned Width   = 3,
  parameter int unsigned LoadVal = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Width'(LoadVal);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_echo_responder.sv
// Echo endpoint on the uart_protocol host port: fetch RX byte, optional upcase, write back,
// optional LF after CR.
module uart_echo_responder
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STATUS_LAT   = 2,
  parameter int unsigned RX_EMPTY_BIT = 0,
  parameter int unsigned TX_FULL_BIT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   upcase_en,
  input  logic                   crlf_en,
  uart_echo_responder_if.master  bus,
  output logic                   busy,
  output logic [15:0]            rx_byte_count,
  output logic [15:0]            tx_byte_count,
  output logic [DATA_SIZE-1:0]   last_byte
);

  localparam int unsigned CntW = 3;

  state_e               state_q, state_d;
  logic [CntW-1:0]      lat_q, lat_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic [DATA_SIZE-1:0] last_q, last_d;
  logic                 lf_pend_q, lf_pend_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic                 busy_q, busy_d;

  logic rx_zero, tx_zero;
  logic rx_empty, tx_full, capture, is_lower;

  assign rx_empty = bus.rx_status[RX_EMPTY_BIT];
  assign tx_full  = bus.tx_status[TX_FULL_BIT];
  assign capture  = (state_q == StRdWait) && (lat_q == CntW'(READ_LAT - 1));
  assign is_lower = (bus.bus_rdata >= DATA_SIZE'(LOWER_A)) &&
                    (bus.bus_rdata <= DATA_SIZE'(LOWER_Z));

  uart_echo_settle_cnt #(
    .Width   (CntW),
    .LoadVal (STATUS_LAT)
  ) u_rx_settle (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (state_q == StRdPulse),
    .zero_o  (rx_zero)
  );

  uart_echo_settle_cnt #(
    .Width   (CntW),
    .LoadVal (STATUS_LAT)
  ) u_tx_settle (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (state_q == StWrPulse),
    .zero_o  (tx_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      hold_q    <= '0;
      last_q    <= '0;
      lf_pend_q <= 1'b0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      lf_pend_q <= lf_pend_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  // Next state plus the datapath registers that advance with it.
  always_comb begin
    state_d   = state_q;
    lat_d     = '0;
    hold_d    = hold_q;
    last_d    = last_q;
    lf_pend_d = lf_pend_q;
    rx_cnt_d  = rx_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable && !rx_empty && rx_zero) state_d = StRdPulse;
      end
      StRdPulse: state_d = StRdWait;
      StRdWait: begin
        lat_d = lat_q + 1'b1;
        if (capture) begin
          last_d    = bus.bus_rdata;
          hold_d    = (upcase_en && is_lower) ? bus.bus_rdata - DATA_SIZE'(CASE_OFFSET)
                                              : bus.bus_rdata;
          rx_cnt_d  = rx_cnt_q + 16'd1;
          lf_pend_d = crlf_en && (bus.bus_rdata == DATA_SIZE'(CHAR_CR));
          state_d   = StTxWait;
        end
      end
      StTxWait: begin
        if (!tx_full && tx_zero) state_d = StWrPulse;
      end
      StWrPulse: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (lf_pend_q) begin
          hold_d    = DATA_SIZE'(CHAR_LF);
          lf_pend_d = 1'b0;
          state_d   = StTxWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so pulses line up with their FSM state.
  always_comb begin
    read_d  = (state_d == StRdPulse);
    write_d = (state_d == StWrPulse);
    wdata_d = write_d ? hold_q : '0;
    busy_d  = (state_d != StIdle);
  end

  assign bus.read_data  = read_q;
  assign bus.write_data = write_q;
  assign bus.bus_wdata  = wdata_q;
  assign busy           = busy_q;
  assign rx_byte_count  = rx_cnt_q;
  assign tx_byte_count  = tx_cnt_q;
  assign last_byte      = last_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder with a small RX/TX FIFO and status-register model.
module tb_uart_echo_responder;

  typedef struct {
    logic [7:0] wdata;
    logic [7:0] raw;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic upcase_en = 1'b0;
  logic crlf_en = 1'b0;
  logic busy;
  logic [15:0] rx_byte_count, tx_byte_count;
  logic [7:0] last_byte;

  logic [7:0] rx_q[$];
  exp_t       exp_q[$];
  logic       rx_empty_r = 1'b1;
  logic       tx_full_r = 1'b0;
  logic       tx_full_src = 1'b0;
  logic [7:0] rdata_r = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_rx = 16'h0;
  logic [15:0] exp_tx = 16'h0;

  uart_echo_responder_if #(.DATA_SIZE(8)) bus_if ();

  uart_echo_responder dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .upcase_en     (upcase_en),
    .crlf_en       (crlf_en),
    .bus           (bus_if),
    .busy          (busy),
    .rx_byte_count (rx_byte_count),
    .tx_byte_count (tx_byte_count),
    .last_byte     (last_byte)
  );

  always #5 clk = ~clk;

  // uart_protocol stand-in: pop on read_data, status flags are registered like real status regs.
  assign bus_if.rx_status = {7'b0, rx_empty_r};
  assign bus_if.tx_status = {6'b0, tx_full_r, 1'b0};
  assign bus_if.bus_rdata = rdata_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.read_data && rx_q.size() > 0) rdata_r <= rx_q.pop_front();
    rx_empty_r <= (rx_q.size() == 0);
    tx_full_r  <= tx_full_src;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: every write pulse is matched against the next expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.read_data && bus_if.write_data) chk("rd_wr_overlap", 1, 0);
      if (bus_if.write_data) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'h0, bus_if.bus_wdata}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wdata", {24'h0, bus_if.bus_wdata}, {24'h0, e.wdata});
          chk("last_byte_at_write", {24'h0, last_byte}, {24'h0, e.raw});
        end
      end
    end
  end

  task automatic send(input logic [7:0] raw, input logic [7:0] wr);
    exp_t e;
    e.raw = raw;
    e.wdata = wr;
    exp_q.push_back(e);
    rx_q.push_back(raw);
  endtask

  task automatic wait_read(output int at, output bit ok);
    ok = 0;
    at = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.read_data) begin
        at = cyc;
        ok = 1;
        return;
      end
    end
    timeout("wait_read");
  endtask

  task automatic wait_write(output int at, output bit ok);
    ok = 0;
    at = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.write_data) begin
        at = cyc;
        ok = 1;
        return;
      end
    end
    timeout("wait_write");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rx_q.size() == 0 && !busy) return;
    end
    timeout(name);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_rx_cnt"}, {16'h0, rx_byte_count}, {16'h0, exp_rx});
    chk({name, "_tx_cnt"}, {16'h0, tx_byte_count}, {16'h0, exp_tx});
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_read"}, {31'h0, bus_if.read_data}, 0);
    chk({name, "_write"}, {31'h0, bus_if.write_data}, 0);
    chk({name, "_busy"}, {31'h0, busy}, 0);
    chk({name, "_wdata"}, {24'h0, bus_if.bus_wdata}, 0);
    chk({name, "_last"}, {24'h0, last_byte}, 0);
    chk({name, "_rx_cnt"}, {16'h0, rx_byte_count}, 0);
    chk({name, "_tx_cnt"}, {16'h0, tx_byte_count}, 0);
  endtask

  initial begin
    int  r, w, w2, k, viol;
    bit  ok, ok2;
    logic [7:0] up_in[4];
    logic [7:0] up_out[4];
    up_in  = '{8'h61, 8'h7A, 8'h7B, 8'h40};
    up_out = '{8'h41, 8'h5A, 8'h7B, 8'h40};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Basic echo and read-to-write latency.
    enable = 1'b1;
    send(8'h41, 8'h41);
    wait_read(r, ok);
    wait_write(w, ok2);
    if (ok && ok2) chk("echo_latency", w - r, 3);
    drain("basic_drain");
    exp_rx = exp_rx + 1;
    exp_tx = exp_tx + 1;
    chk_counts("basic");
    chk("basic_busy_idle", {31'h0, busy}, 0);

    // Upcase mapping, including the boundaries just outside a..z.
    upcase_en = 1'b1;
    for (int i = 0; i < 4; i++) send(up_in[i], up_out[i]);
    drain("upcase_drain");
    exp_rx = exp_rx + 4;
    exp_tx = exp_tx + 4;
    chk_counts("upcase");
    chk("upcase_last_raw", {24'h0, last_byte}, 32'h40);
    upcase_en = 1'b0;

    // CR followed by an inserted LF.
    crlf_en = 1'b1;
    send(8'h0D, 8'h0D);
    begin
      exp_t e;
      e.raw = 8'h0D;
      e.wdata = 8'h0A;
      exp_q.push_back(e);
    end
    wait_write(w, ok);
    wait_write(w2, ok2);
    if (ok && ok2) chk("lf_gap_ge_3", {31'h0, (w2 - w) >= 3}, 1);
    drain("crlf_drain");
    exp_rx = exp_rx + 1;
    exp_tx = exp_tx + 2;
    chk_counts("crlf");
    crlf_en = 1'b0;

    // TX back-pressure: FIFO full for 50 cycles after capture.
    tx_full_src = 1'b1;
    send(8'h55, 8'h55);
    wait_read(r, ok);
    repeat (2) @(negedge clk);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.write_data || !busy) viol++;
    end
    chk("backpressure_hold", viol, 0);
    @(posedge clk);
    #1 tx_full_src = 1'b0;
    k = 0;
    ok = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.write_data) begin
        k = i;
        ok = 1;
        break;
      end
    end
    if (ok) chk("backpressure_release_latency", k, 2);
    else timeout("backpressure_release");
    drain("bp_drain");
    exp_rx = exp_rx + 1;
    exp_tx = exp_tx + 1;
    chk_counts("backpressure");

    // Reset while waiting on TX with an LF pending: nothing is written afterwards.
    crlf_en = 1'b1;
    tx_full_src = 1'b1;
    rx_q.push_back(8'h0D);
    wait_read(r, ok);
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk_all_zero("mid_reset");
    exp_rx = 16'h0;
    exp_tx = 16'h0;
    tx_full_src = 1'b0;
    crlf_en = 1'b0;
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.write_data) viol++;
    end
    chk("no_write_after_reset", viol, 0);

    // Enable gating, then deassert enable mid-transfer.
    enable = 1'b0;
    send(8'h33, 8'h33);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.read_data) viol++;
    end
    chk("enable_gates_read", viol, 0);
    enable = 1'b1;
    wait_read(r, ok);
    @(posedge clk);
    #1 enable = 1'b0;
    drain("enable_drain");
    exp_rx = exp_rx + 1;
    exp_tx = exp_tx + 1;
    chk_counts("enable_midflight");

    // Counter wrap from 0xFFFF.
    enable = 1'b1;
    @(negedge clk);
    force dut.rx_cnt_q = 16'hFFFF;
    force dut.tx_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.rx_cnt_q;
    release dut.tx_cnt_q;
    exp_rx = 16'hFFFF;
    exp_tx = 16'hFFFF;
    chk_counts("preload");
    send(8'h21, 8'h21);
    drain("wrap_drain");
    exp_rx = exp_rx + 16'd1;
    exp_tx = exp_tx + 16'd1;
    chk_counts("wrap");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
